// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared constants, field positions and request decode for the banked memory responder.
package mem_if_pkg;
  localparam int BANK_CNT = 4;
  localparam int BUSY_CYC = 4;
  localparam int RD_LAT = 2;
  localparam int BANK_LSB = 1;
  localparam int BANK_MSB = 2;
  localparam int ROW_LSB = 3;
  typedef logic [BANK_MSB-BANK_LSB:0] bank_t;
  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR, OP_ILL} op_e;
  function automatic op_e decode(input logic rd, input logic wr, input logic a0);
    return (rd & wr) | ((rd | wr) & a0) ? OP_ILL : rd ? OP_RD : wr ? OP_WR : OP_NONE;
  endfunction
endpackage

// File: rtl/banked_mem_responder_if.sv
// banked_mem_responder_if: cache-to-memory request bus between a controller and the banked responder.
interface banked_mem_responder_if;
  import mem_if_pkg::*;
  logic createdump;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic wr;
  logic rd;
  logic [15:0] data_out;
  logic stall;
  logic [BANK_CNT-1:0] busy;
  logic err;
  modport master(output createdump, addr, data_in, wr, rd, input data_out, stall, busy, err);
  modport slave(input createdump, addr, data_in, wr, rd, output data_out, stall, busy, err);
endinterface

// File: rtl/bank_busy_ctr.sv
// bank_busy_ctr: per-bank occupancy counter, loads on accept and counts down to idle.
module bank_busy_ctr #(
  parameter int BUSY_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);
  localparam int W = $clog2(BUSY_CYC);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(BUSY_CYC - 1);
    else if (cnt != '0) cnt <= cnt - W'(1);
  end
  assign busy = cnt != '0;
endmodule

// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four word-interleaved banks with per-bank busy windows and fixed-latency reads.
module banked_mem_responder
  import mem_if_pkg::*;
#(
  parameter int BANK_DEPTH_LOG2 = 13
) (
  input logic clk,
  input logic rst,
  banked_mem_responder_if.slave m
);
  op_e op;
  bank_t bank;
  logic [BANK_DEPTH_LOG2-1:0] row;
  logic [BANK_CNT-1:0] busy;
  logic [BANK_CNT-1:0] load;
  logic rd_acc;
  logic wr_acc;
  logic [15:0] mem [BANK_CNT][2**BANK_DEPTH_LOG2];
  logic [15:0] pipe [RD_LAT];
  assign op = decode(m.rd, m.wr, m.addr[0]);
  assign bank = m.addr[BANK_MSB:BANK_LSB];
  assign row = m.addr[ROW_LSB +: BANK_DEPTH_LOG2];
  assign rd_acc = (op == OP_RD) && !busy[bank];
  assign wr_acc = (op == OP_WR) && !busy[bank];
  assign load = (rd_acc | wr_acc) ? BANK_CNT'(1) << bank : '0;
  assign m.err = op == OP_ILL;
  assign m.stall = (op == OP_RD || op == OP_WR) && busy[bank];
  assign m.busy = busy;
  assign m.data_out = pipe[RD_LAT-1];
  for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
    bank_busy_ctr #(.BUSY_CYC(BUSY_CYC)) u_ctr (.clk(clk), .rst(rst), .load(load[b]), .busy(busy[b]));
  end
  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[bank][row] <= m.data_in;
  end
  // Zeros flow through the pipe when no read lands, so data_out is 0 outside its valid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '{default: '0};
    else begin
      pipe[0] <= rd_acc ? mem[bank][row] : '0;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule
